// File: rtl/graph_conv_pkg.sv
// Shared constants for the graph-conv FIFO wrapper: widths, event field layout and feeder states.
package graph_conv_pkg;

   localparam int unsigned FIFO_WIDTH = 72;
   localparam int unsigned MAX_DEGREE = 16;
   localparam int unsigned CNT_WIDTH  = 16;
   localparam int unsigned F_WIDTH    = 8;
   localparam int unsigned ADDR_WIDTH = 32;

   // Event word layout: addr/ts in the low bits, two 8-bit fields above, remainder reserved.
   localparam int unsigned EVT_ADDR_LSB = 0;
   localparam int unsigned EVT_F0_LSB   = EVT_ADDR_LSB + ADDR_WIDTH;
   localparam int unsigned EVT_F1_LSB   = EVT_F0_LSB + F_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_FILL      = 2'd1,
      ST_START     = 2'd2,
      ST_WAIT_DONE = 2'd3
   } feeder_state_e;

endpackage

// File: rtl/neighbour_fifo_feeder.sv
// Accepts one event plus its neighbour list, writes up to MAX_DEGREE neighbours into the
// neighbour FIFO, then launches graph_conv and holds off the next event until it reports done.
module neighbour_fifo_feeder #(
   parameter int unsigned FIFO_WIDTH = graph_conv_pkg::FIFO_WIDTH,
   parameter int unsigned MAX_DEGREE = graph_conv_pkg::MAX_DEGREE,
   parameter int unsigned CNT_WIDTH  = graph_conv_pkg::CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  s_evt_valid,
   output logic                  s_evt_ready,
   input  logic [FIFO_WIDTH-1:0] s_evt_data,
   input  logic                  s_evt_no_nb,
   input  logic                  s_nb_valid,
   output logic                  s_nb_ready,
   input  logic [FIFO_WIDTH-1:0] s_nb_data,
   input  logic                  s_nb_last,
   output logic                  fifo_wr_en,
   output logic [FIFO_WIDTH-1:0] fifo_din,
   input  logic                  fifo_full,
   output logic                  module_start,
   output logic [FIFO_WIDTH-1:0] new_event,
   input  logic                  module_done,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  dropped_cnt
);
   import graph_conv_pkg::*;

   localparam int unsigned NB_CNT_W = $clog2(MAX_DEGREE + 1);

   feeder_state_e         state_q, state_d;
   logic [NB_CNT_W-1:0]   nb_cnt_q, nb_cnt_d;
   logic [CNT_WIDTH-1:0]  dropped_q, dropped_d;
   logic [FIFO_WIDTH-1:0] event_q, event_d;
   logic                  at_max;
   logic                  nb_hs;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         nb_cnt_q  <= '0;
         dropped_q <= '0;
         event_q   <= '0;
      end else begin
         state_q   <= state_d;
         nb_cnt_q  <= nb_cnt_d;
         dropped_q <= dropped_d;
         event_q   <= event_d;
      end
   end

   // Once the list is full, further neighbours are drained (and counted) even while the FIFO is full.
   assign at_max = (nb_cnt_q == NB_CNT_W'(MAX_DEGREE));

   always_comb begin
      state_d      = state_q;
      nb_cnt_d     = nb_cnt_q;
      dropped_d    = dropped_q;
      event_d      = event_q;
      s_evt_ready  = 1'b0;
      s_nb_ready   = 1'b0;
      fifo_wr_en   = 1'b0;
      fifo_din     = '0;
      module_start = 1'b0;
      nb_hs        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            s_evt_ready = rstn;
            if (s_evt_valid) begin
               event_d  = s_evt_data;
               nb_cnt_d = '0;
               state_d  = s_evt_no_nb ? ST_START : ST_FILL;
            end
         end
         ST_FILL: begin
            s_nb_ready = !fifo_full || at_max;
            nb_hs      = s_nb_valid && s_nb_ready;
            if (nb_hs) begin
               if (!at_max) begin
                  fifo_wr_en = 1'b1;
                  fifo_din   = s_nb_data;
                  nb_cnt_d   = nb_cnt_q + NB_CNT_W'(1);
               end else if (dropped_q != {CNT_WIDTH{1'b1}}) begin
                  dropped_d = dropped_q + CNT_WIDTH'(1);
               end
               if (s_nb_last) begin
                  state_d = ST_START;
               end
            end
         end
         ST_START: begin
            module_start = 1'b1;
            state_d      = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (module_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign new_event   = event_q;
   assign dropped_cnt = dropped_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_neighbour_fifo_feeder.sv
// Randomised bench for neighbour_fifo_feeder against a list-level model of truncation, drop counting and launch.
module tb_neighbour_fifo_feeder;
   import graph_conv_pkg::*;

   localparam int unsigned FW = FIFO_WIDTH;
   localparam int unsigned CW = CNT_WIDTH;

   logic          clk = 1'b0;
   logic          rstn;
   logic          s_evt_valid, s_evt_ready, s_evt_no_nb;
   logic [FW-1:0] s_evt_data;
   logic          s_nb_valid, s_nb_ready, s_nb_last;
   logic [FW-1:0] s_nb_data;
   logic          fifo_wr_en, fifo_full;
   logic [FW-1:0] fifo_din;
   logic          module_start, module_done, busy;
   logic [FW-1:0] new_event;
   logic [CW-1:0] dropped_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int start_total = 0;
   int start_cyc   = 0;
   int wr_full_viol = 0;
   int model_drop = 0;
   int acc_cyc = 0;
   int last_hs_cyc = 0;
   logic [FW-1:0] got_q[$];
   logic [FW-1:0] nbs[$];

   neighbour_fifo_feeder dut (
      .clk          (clk),
      .rstn         (rstn),
      .s_evt_valid  (s_evt_valid),
      .s_evt_ready  (s_evt_ready),
      .s_evt_data   (s_evt_data),
      .s_evt_no_nb  (s_evt_no_nb),
      .s_nb_valid   (s_nb_valid),
      .s_nb_ready   (s_nb_ready),
      .s_nb_data    (s_nb_data),
      .s_nb_last    (s_nb_last),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_din     (fifo_din),
      .fifo_full    (fifo_full),
      .module_start (module_start),
      .new_event    (new_event),
      .module_done  (module_done),
      .busy         (busy),
      .dropped_cnt  (dropped_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Passive monitor: collects FIFO writes and start pulses at the falling edge.
   always @(negedge clk) begin
      if (fifo_wr_en) begin
         got_q.push_back(fifo_din);
         if (fifo_full) wr_full_viol <= wr_full_viol + 1;
      end
      if (module_start) begin
         start_total <= start_total + 1;
         start_cyc   <= cyc;
      end
   end

   function automatic logic [FW-1:0] rand_word();
      return FW'({$urandom(), $urandom(), $urandom()});
   endfunction

   task automatic make_list(input int n);
      nbs.delete();
      for (int k = 0; k < n; k++) nbs.push_back(rand_word());
   endtask

   task automatic accept_event(input logic [FW-1:0] evt, input logic no_nb, output int waited);
      logic acc;
      acc = 1'b0;
      waited = 0;
      s_evt_valid = 1'b1;
      s_evt_data  = evt;
      s_evt_no_nb = no_nb;
      while (!acc && waited < 50) begin
         @(negedge clk);
         if (s_evt_ready) begin
            acc = 1'b1;
            acc_cyc = cyc;
         end
         @(posedge clk); #1;
         if (!acc) waited++;
      end
      s_evt_valid = 1'b0;
      s_evt_no_nb = 1'b0;
      total++;
      if (!acc) begin
         bad++;
         $display("FAIL evt_accept: not accepted within %0d cycles", waited);
      end
   endtask

   task automatic feed_nbs(input int full_at, input int full_len, input int gap_pct,
                           input int done_at);
      int i, c, rdy_err;
      logic hs, exp_rdy;
      i = 0; c = 0; rdy_err = 0;
      while (i < nbs.size() && c < 2000) begin
         fifo_full   = (c >= full_at) && (c < full_at + full_len);
         module_done = (c == done_at);
         s_nb_valid  = ($urandom_range(99) >= gap_pct);
         s_nb_data   = nbs[i];
         s_nb_last   = (i == nbs.size() - 1);
         @(negedge clk);
         exp_rdy = !fifo_full || (i >= int'(MAX_DEGREE));
         if (s_nb_ready !== exp_rdy) rdy_err++;
         hs = s_nb_valid && s_nb_ready;
         if (hs && s_nb_last) last_hs_cyc = cyc;
         @(posedge clk); #1;
         if (hs) i++;
         c++;
      end
      s_nb_valid = 1'b0; s_nb_last = 1'b0; fifo_full = 1'b0; module_done = 1'b0;
      total++;
      if (i != nbs.size()) begin
         bad++;
         $display("FAIL nb_feed: handshakes=%0d required=%0d", i, nbs.size());
      end
      total++;
      if (rdy_err != 0) begin
         bad++;
         $display("FAIL nb_ready: wrong s_nb_ready in %0d cycles, required 0", rdy_err);
      end
   endtask

   // Checks one launched event against the model; leaves the DUT in WAIT_DONE.
   task automatic check_event(input string tag, input logic [FW-1:0] evt, input int n,
                              input int start_base, input int viol_base);
      int nwr, exp_start;
      nwr = (n > int'(MAX_DEGREE)) ? int'(MAX_DEGREE) : n;
      if (n > int'(MAX_DEGREE)) model_drop = model_drop + (n - int'(MAX_DEGREE));
      if (model_drop > 65535) model_drop = 65535;
      exp_start = (n == 0) ? acc_cyc + 1 : last_hs_cyc + 1;
      repeat (3) @(negedge clk);
      total++;
      if (start_total - start_base !== 1) begin
         bad++;
         $display("FAIL %s start_count: got=%0d required=1", tag, start_total - start_base);
      end
      total++;
      if (start_cyc !== exp_start) begin
         bad++;
         $display("FAIL %s start_latency: start_cyc=%0d required=%0d", tag, start_cyc, exp_start);
      end
      total++;
      if (got_q.size() != nwr) begin
         bad++;
         $display("FAIL %s write_count: got=%0d required=%0d", tag, got_q.size(), nwr);
      end else begin
         for (int k = 0; k < nwr; k++) begin
            total++;
            if (got_q[k] !== nbs[k]) begin
               bad++;
               $display("FAIL %s write_data[%0d]: got=%h required=%h", tag, k, got_q[k], nbs[k]);
            end
         end
      end
      total++;
      if (new_event !== evt) begin
         bad++;
         $display("FAIL %s new_event: got=%h required=%h", tag, new_event, evt);
      end
      total++;
      if (dropped_cnt !== CW'(model_drop)) begin
         bad++;
         $display("FAIL %s dropped_cnt: got=%0d required=%0d", tag, dropped_cnt, model_drop);
      end
      total++;
      if (busy !== 1'b1 || s_evt_ready !== 1'b0) begin
         bad++;
         $display("FAIL %s wait_state: busy=%b ready=%b required busy=1 ready=0",
                  tag, busy, s_evt_ready);
      end
      total++;
      if (wr_full_viol - viol_base != 0) begin
         bad++;
         $display("FAIL %s write_while_full: got=%0d required=0", tag, wr_full_viol - viol_base);
      end
   endtask

   task automatic release_done(input string tag);
      @(posedge clk); #1;
      module_done = 1'b1;
      @(posedge clk); #1;
      module_done = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || s_evt_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s after_done: busy=%b ready=%b required busy=0 ready=1",
                  tag, busy, s_evt_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic run_event(input string tag, input int n, input int full_at, input int full_len,
                            input int gap_pct);
      logic [FW-1:0] evt;
      int sb, vb, w;
      evt = rand_word();
      make_list(n);
      got_q.delete();
      sb = start_total; vb = wr_full_viol;
      accept_event(evt, (n == 0), w);
      if (n > 0) feed_nbs(full_at, full_len, gap_pct, -1);
      check_event(tag, evt, n, sb, vb);
      release_done(tag);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      s_evt_valid = 1'b0; s_evt_data = '0; s_evt_no_nb = 1'b0;
      s_nb_valid = 1'b0; s_nb_data = '0; s_nb_last = 1'b0;
      fifo_full = 1'b0; module_done = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({fifo_wr_en, module_start, busy, s_evt_ready, s_nb_ready} !== 5'b0 ||
          new_event !== '0 || fifo_din !== '0 || dropped_cnt !== '0) begin
         bad++;
         $display("FAIL reset_outputs: wr=%b st=%b busy=%b er=%b nr=%b ev=%h din=%h drop=%0d required all 0",
                  fifo_wr_en, module_start, busy, s_evt_ready, s_nb_ready, new_event, fifo_din, dropped_cnt);
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      total++;
      if (s_evt_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: ready=%b busy=%b required ready=1 busy=0", s_evt_ready, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_three_nb();
      run_event("three_nb", 3, -1, 0, 0);
   endtask

   task automatic test_overflow();
      run_event("overflow20", 20, -1, 0, 0);
   endtask

   task automatic test_fifo_full();
      run_event("fifo_full", 8, 3, 5, 0);
   endtask

   task automatic test_no_nb();
      run_event("no_nb", 0, -1, 0, 0);
   endtask

   task automatic test_spurious_done();
      logic [FW-1:0] evt1, evt2;
      int sb, vb, w, stall_err;
      // Pulse done while idle: must be ignored.
      module_done = 1'b1;
      @(posedge clk); #1;
      module_done = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || s_evt_ready !== 1'b1 || module_start !== 1'b0) begin
         bad++;
         $display("FAIL idle_done: busy=%b ready=%b start=%b required 0/1/0", busy, s_evt_ready, module_start);
      end
      @(posedge clk); #1;
      evt1 = rand_word();
      make_list(5);
      got_q.delete();
      sb = start_total; vb = wr_full_viol;
      accept_event(evt1, 1'b0, w);
      feed_nbs(-1, 0, 0, 1);
      check_event("done_in_fill", evt1, 5, sb, vb);
      evt2 = rand_word();
      stall_err = 0;
      s_evt_valid = 1'b1; s_evt_data = evt2; s_evt_no_nb = 1'b1;
      for (int k = 0; k < 5; k++) begin
         module_done = (k == 4);
         @(negedge clk);
         if (s_evt_ready !== 1'b0 || busy !== 1'b1) stall_err++;
         @(posedge clk); #1;
      end
      module_done = 1'b0;
      total++;
      if (stall_err != 0) begin
         bad++;
         $display("FAIL second_evt_stall: bad cycles=%0d required 0", stall_err);
      end
      nbs.delete();
      got_q.delete();
      sb = start_total; vb = wr_full_viol;
      accept_event(evt2, 1'b1, w);
      total++;
      if (w != 0) begin
         bad++;
         $display("FAIL accept_after_done: waited=%0d required=0", w);
      end
      check_event("second_evt", evt2, 0, sb, vb);
      release_done("second_evt");
   endtask

   task automatic test_reset_mid();
      logic [FW-1:0] evt;
      int w;
      evt = rand_word();
      make_list(6);
      got_q.delete();
      accept_event(evt, 1'b0, w);
      for (int k = 0; k < 2; k++) begin
         s_nb_valid = 1'b1; s_nb_data = nbs[k]; s_nb_last = 1'b0;
         @(posedge clk); #1;
      end
      total++;
      if (got_q.size() != 2) begin
         bad++;
         $display("FAIL pre_reset_writes: got=%0d required=2", got_q.size());
      end
      rstn = 1'b0;
      @(negedge clk);
      total++;
      if ({fifo_wr_en, module_start, busy, s_evt_ready, s_nb_ready} !== 5'b0 ||
          new_event !== '0 || fifo_din !== '0 || dropped_cnt !== '0) begin
         bad++;
         $display("FAIL mid_reset_outputs: wr=%b st=%b busy=%b er=%b nr=%b ev=%h drop=%0d required all 0",
                  fifo_wr_en, module_start, busy, s_evt_ready, s_nb_ready, new_event, dropped_cnt);
      end
      @(posedge clk); #1;
      s_nb_valid = 1'b0;
      rstn = 1'b1;
      model_drop = 0;
      @(posedge clk); #1;
      run_event("post_reset18", 18, -1, 0, 0);
   endtask

   task automatic test_random();
      for (int e = 0; e < 10; e++) begin
         int n, fa, fl;
         n  = $urandom_range(24);
         fa = $urandom_range(10);
         fl = $urandom_range(6);
         run_event($sformatf("rand%0d", e), n, fa, fl, 30);
      end
   endtask

   initial begin
      test_reset();
      test_three_nb();
      test_overflow();
      test_fifo_full();
      test_no_nb();
      test_spurious_done();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
